// File: rtl/sys_ctrl.sv
`default_nettype none
// sys_ctrl: UART command decoder steering register-file writes/reads, ALU ops and TX FIFO pushes.
// Rev 1.0
module sys_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]     RdData,
   input  logic                      RdData_Valid,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      OUT_Valid,
   input  logic                      FIFO_FULL,
   output logic                      WrEn,
   output logic                      RdEn,
   output logic [ADDRESS_WIDTH-1:0]  Address,
   output logic [DATA_WIDTH-1:0]     WrData,
   output logic                      ALU_EN,
   output logic [3:0]                ALU_FUN,
   output logic                      CLK_EN,
   output logic [DATA_WIDTH-1:0]     TX_DATA,
   output logic                      TX_WR
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WR_ADDR  = 4'd1;
   localparam logic [3:0] S_WR_DATA  = 4'd2;
   localparam logic [3:0] S_RD_ADDR  = 4'd3;
   localparam logic [3:0] S_RD_WAIT  = 4'd4;
   localparam logic [3:0] S_OP_A     = 4'd5;
   localparam logic [3:0] S_OP_B     = 4'd6;
   localparam logic [3:0] S_ALU_FN   = 4'd7;
   localparam logic [3:0] S_ALU_WAIT = 4'd8;
   localparam logic [3:0] S_TX_LSB   = 4'd9;
   localparam logic [3:0] S_TX_MSB   = 4'd10;
   localparam logic [3:0] S_TX_RD    = 4'd11;

   localparam logic [DATA_WIDTH-1:0] C_CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] C_CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] C_CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] C_CMD_ALU_NO = DATA_WIDTH'(8'hDD);

   logic [3:0]                r_state;
   logic [3:0]                w_next;

   logic                      r_wr_en,   w_wr_en;
   logic                      r_rd_en,   w_rd_en;
   logic [ADDRESS_WIDTH-1:0]  r_addr,    w_addr;
   logic [DATA_WIDTH-1:0]     r_wr_data, w_wr_data;
   logic                      r_alu_en,  w_alu_en;
   logic [3:0]                r_alu_fun, w_alu_fun;
   logic                      r_clk_en,  w_clk_en;
   logic [DATA_WIDTH-1:0]     r_tx_data, w_tx_data;
   logic                      r_tx_wr,   w_tx_wr;
   logic [2*DATA_WIDTH-1:0]   r_result,  w_result;
   logic [DATA_WIDTH-1:0]     r_rd_data, w_rd_data;

   // State and every output are registered here; the comb blocks only compute next values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_alu_en  <= 1'b0;
         r_alu_fun <= '0;
         r_clk_en  <= 1'b0;
         r_tx_data <= '0;
         r_tx_wr   <= 1'b0;
         r_result  <= '0;
         r_rd_data <= '0;
      end else begin
         r_state   <= w_next;
         r_wr_en   <= w_wr_en;
         r_rd_en   <= w_rd_en;
         r_addr    <= w_addr;
         r_wr_data <= w_wr_data;
         r_alu_en  <= w_alu_en;
         r_alu_fun <= w_alu_fun;
         r_clk_en  <= w_clk_en;
         r_tx_data <= w_tx_data;
         r_tx_wr   <= w_tx_wr;
         r_result  <= w_result;
         r_rd_data <= w_rd_data;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  C_CMD_WR:     w_next = S_WR_ADDR;
                  C_CMD_RD:     w_next = S_RD_ADDR;
                  C_CMD_ALU_OP: w_next = S_OP_A;
                  C_CMD_ALU_NO: w_next = S_ALU_FN;
                  default:      w_next = S_IDLE;
               endcase
            end
         end
         S_WR_ADDR:  if (RX_D_VLD)   w_next = S_WR_DATA;
         S_WR_DATA:  if (RX_D_VLD)   w_next = S_IDLE;
         S_RD_ADDR:  if (RX_D_VLD)   w_next = S_RD_WAIT;
         S_RD_WAIT:  if (RdData_Valid) w_next = S_TX_RD;
         S_OP_A:     if (RX_D_VLD)   w_next = S_OP_B;
         S_OP_B:     if (RX_D_VLD)   w_next = S_ALU_FN;
         S_ALU_FN:   if (RX_D_VLD)   w_next = S_ALU_WAIT;
         S_ALU_WAIT: if (OUT_Valid)  w_next = S_TX_LSB;
         S_TX_LSB:   if (!FIFO_FULL) w_next = S_TX_MSB;
         S_TX_MSB:   if (!FIFO_FULL) w_next = S_IDLE;
         S_TX_RD:    if (!FIFO_FULL) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_wr_en   = 1'b0;
      w_rd_en   = 1'b0;
      w_alu_en  = 1'b0;
      w_tx_wr   = 1'b0;
      w_addr    = r_addr;
      w_wr_data = r_wr_data;
      w_alu_fun = r_alu_fun;
      w_tx_data = r_tx_data;
      w_result  = r_result;
      w_rd_data = r_rd_data;
      case (r_state)
         S_WR_ADDR: if (RX_D_VLD) w_addr = RX_P_DATA[ADDRESS_WIDTH-1:0];
         S_WR_DATA: begin
            if (RX_D_VLD) begin
               w_wr_en   = 1'b1;
               w_wr_data = RX_P_DATA;
            end
         end
         S_RD_ADDR: begin
            if (RX_D_VLD) begin
               w_rd_en = 1'b1;
               w_addr  = RX_P_DATA[ADDRESS_WIDTH-1:0];
            end
         end
         S_RD_WAIT: if (RdData_Valid) w_rd_data = RdData;
         S_OP_A, S_OP_B: begin
            if (RX_D_VLD) begin
               w_wr_en   = 1'b1;
               w_addr    = (r_state == S_OP_A) ? ADDRESS_WIDTH'(0) : ADDRESS_WIDTH'(1);
               w_wr_data = RX_P_DATA;
            end
         end
         S_ALU_FN: begin
            if (RX_D_VLD) begin
               w_alu_en  = 1'b1;
               w_alu_fun = RX_P_DATA[3:0];
            end
         end
         S_ALU_WAIT: if (OUT_Valid) w_result = ALU_OUT;
         S_TX_LSB: begin
            if (!FIFO_FULL) begin
               w_tx_wr   = 1'b1;
               w_tx_data = r_result[DATA_WIDTH-1:0];
            end
         end
         S_TX_MSB: begin
            if (!FIFO_FULL) begin
               w_tx_wr   = 1'b1;
               w_tx_data = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
            end
         end
         S_TX_RD: begin
            if (!FIFO_FULL) begin
               w_tx_wr   = 1'b1;
               w_tx_data = r_rd_data;
            end
         end
         default: ;
      endcase
      // The ALU clock stays gated on for the whole ALU_FN..ALU_WAIT span.
      w_clk_en = (w_next == S_ALU_FN) || (w_next == S_ALU_WAIT);
   end

   assign WrEn    = r_wr_en;
   assign RdEn    = r_rd_en;
   assign Address = r_addr;
   assign WrData  = r_wr_data;
   assign ALU_EN  = r_alu_en;
   assign ALU_FUN = r_alu_fun;
   assign CLK_EN  = r_clk_en;
   assign TX_DATA = r_tx_data;
   assign TX_WR   = r_tx_wr;

endmodule
`default_nettype wire

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning command/data byte width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port RX_P_DATA  input  DATA_WIDTH  received UART byte.
REQ-006 SHALL have port RX_D_VLD  input  1  RX_P_DATA valid for one cycle.
REQ-007 SHALL have port RdData  input  DATA_WIDTH  register-file read data.
REQ-008 SHALL have port RdData_Valid  input  1  register-file read data valid.
REQ-009 SHALL have port ALU_OUT  input  2*DATA_WIDTH  ALU result.
REQ-010 SHALL have port OUT_Valid  input  1  ALU result valid.
REQ-011 SHALL have port FIFO_FULL  input  1  TX FIFO cannot accept a byte.
REQ-012 SHALL have port WrEn  output  1  register-file write strobe.
REQ-013 SHALL have port RdEn  output  1  register-file read strobe.
REQ-014 SHALL have port Address  output  ADDRESS_WIDTH  register-file address.
REQ-015 SHALL have port WrData  output  DATA_WIDTH  register-file write data.
REQ-016 SHALL have port ALU_EN  output  1  ALU operation enable.
REQ-017 SHALL have port ALU_FUN  output  4  ALU function code.
REQ-018 SHALL have port CLK_EN  output  1  ALU clock-gate enable.
REQ-019 SHALL have port TX_DATA  output  DATA_WIDTH  byte pushed to TX FIFO.
REQ-020 SHALL have port TX_WR  output  1  TX FIFO push strobe, one cycle per byte.

Function
REQ-021 SHALL decode commands in IDLE only on RX_D_VLD=1: 0xAA reg write, 0xBB reg read, 0xCC ALU with operands, 0xDD ALU no operands; any other byte ignored, stay IDLE.
REQ-022 SHALL use states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FN, ALU_WAIT, TX_LSB, TX_MSB, TX_RD.
REQ-023 0xAA: WR_ADDR captures address byte (low ADDRESS_WIDTH bits); WR_DATA on next byte asserts WrEn for exactly one cycle with captured Address and WrData=byte; then IDLE.
REQ-024 0xBB: RD_ADDR captures address, asserts RdEn one cycle, enters RD_WAIT; RdData captured the following cycle (RdData_Valid=1); then TX_RD.
REQ-025 0xCC: OP_A byte -> WrEn, Address=0; OP_B byte -> WrEn, Address=1; then ALU_FN.
REQ-026 0xDD: go directly to ALU_FN, register contents 0/1 unchanged.
REQ-027 ALU_FN: on byte, ALU_FUN=byte[3:0], ALU_EN=1 for one cycle, CLK_EN=1 from ALU_FN entry through ALU_WAIT exit; ALU_WAIT waits for OUT_Valid, latching ALU_OUT.
REQ-028 TX_LSB pushes result[7:0], TX_MSB pushes result[15:8]; TX_RD pushes read byte; each push holds state while FIFO_FULL=1, TX_WR=1 only in a cycle with FIFO_FULL=0.
REQ-029 WrEn and RdEn SHALL never be asserted in the same cycle.
REQ-030 RX_D_VLD arriving in RD_WAIT, ALU_WAIT or any TX state SHALL be ignored (byte dropped).
REQ-031 ALU_WAIT with no OUT_Valid SHALL wait indefinitely; no timeout.
REQ-032 All strobe outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 On RST=0, regardless of state: state=IDLE; WrEn, RdEn, ALU_EN, CLK_EN, TX_WR=0; Address, WrData, ALU_FUN, TX_DATA, latched result/read data=0.
REQ-034 Reset mid-command SHALL discard partial command; first byte after release is decoded as a command.

Verification
REQ-035 Bytes AA,05,3C -> one-cycle WrEn, Address=5, WrData=0x3C; no TX_WR.
REQ-036 AA,05,3C then BB,05 -> one RdEn at Address=5, then TX_WR with TX_DATA=0x3C.
REQ-037 CC,07,03,00 (ALU returns 0x000A) -> writes addr0=07, addr1=03, ALU_EN with ALU_FUN=0, TX_WR 0x0A then 0x00.
REQ-038 DD,02 with FIFO_FULL=1 for 5 cycles after OUT_Valid (ALU_OUT=0x1234) -> no TX_WR while full, then 0x34, 0x12.
REQ-039 Byte 0x55 in IDLE -> no strobes; RST=0 after AA,05 then AA,06,11 -> single write Address=6, WrData=0x11.
